// File: rtl/if_fetch.sv
// Instruction-fetch stage: turns PC/ce from the PC register into req/ack word reads
// and presents {pc, inst, valid} to decode, with stall hold and jump flush.
module if_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              jump,
  input  logic              stall_i,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              if_stall_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t            state, next_state;
  logic              take;
  logic              req_done;
  logic              hold_rel;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;

  assign req_done   = (state == REQ) && mem_ack_i;
  assign hold_rel   = (state == HOLD) && !stall_i;
  assign take       = ce_i && !jump &&
                      ((state == IDLE) || (req_done && !stall_i) || hold_rel);
  assign if_stall_o = !take;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (jump) begin
      // A flushed request still owes memory its ack; an ack arriving now retires it.
      unique case (state)
        REQ, DRAIN: next_state = mem_ack_i ? IDLE : DRAIN;
        default:    next_state = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE:  if (take) next_state = REQ;
        REQ: begin
          if (mem_ack_i) begin
            if (stall_i)   next_state = HOLD;
            else           next_state = take ? REQ : IDLE;
          end
        end
        HOLD:  if (!stall_i) next_state = take ? REQ : IDLE;
        DRAIN: if (mem_ack_i) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // NOTE: every register here uses <= so all updates see pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      id_pc_o    <= '0;
      id_inst_o  <= NOP_INST;
      id_valid_o <= 1'b0;
      buf_pc     <= '0;
      buf_inst   <= '0;
    end else begin
      mem_req_o <= (next_state == REQ) || (next_state == DRAIN);
      if (take) mem_addr_o <= pc_i;

      if (jump) begin
        id_valid_o <= 1'b0;
        id_inst_o  <= NOP_INST;
      end else if (req_done && !stall_i) begin
        id_pc_o    <= mem_addr_o;
        id_inst_o  <= mem_rdata_i;
        id_valid_o <= 1'b1;
      end else if (hold_rel) begin
        id_pc_o    <= buf_pc;
        id_inst_o  <= buf_inst;
        id_valid_o <= 1'b1;
      end else if (!stall_i) begin
        // Decode consumed what it had and nothing new is ready: present a bubble.
        id_inst_o  <= NOP_INST;
        id_valid_o <= 1'b0;
      end

      if (!jump && req_done && stall_i) begin
        buf_pc   <= mem_addr_o;
        buf_inst <= mem_rdata_i;
      end
    end
  end

endmodule
